// File: rtl/x_pixel_filling.sv
// Horizontal hole filling over rows 7..232 of the 320x240 frame RAM. A pixel whose left
// and right neighbours both hold 1 is rewritten as 1; otherwise its own value is written back.
module x_pixel_filling (
    input  logic        clk_div_by_two,
    input  logic        reset,
    input  logic        pause,
    input  logic        enable_x_pixel_filling,
    input  logic [31:0] data_read,
    output logic        wren,
    output logic [31:0] data_write,
    output logic [17:0] address,
    output logic        x_pixel_filling_done,
    output logic [2:0]  fsm_state
);

    typedef enum logic [2:0] {IDLE, INIT, RD_C, RD_R, RD_L, WRITE, NEXT, DONE} state_t;

    localparam logic [17:0] FIRST_P  = 18'd2240;   // row 7, column 0
    localparam logic [17:0] END_P    = 18'd74560;  // row 233, column 0
    localparam logic [8:0]  LAST_COL = 9'd319;
    localparam logic [31:0] FILL     = 32'd1;

    state_t      state, state_nxt;
    logic [17:0] p, p_nxt, p_inc, address_nxt;
    logic [8:0]  col, col_nxt;
    logic [31:0] center_px, center_nxt, right_px, right_nxt, left_px, left_nxt;
    logic [31:0] data_write_nxt;
    logic        wr_phase, wr_phase_nxt, wren_nxt, done_nxt;

    assign p_inc     = p + 18'd1;
    assign fsm_state = state;

    // All outputs are registered. RAM read data arrives one clock after the address is
    // visible, so every read address is set up one state ahead of the state capturing it;
    // WRITE spends one cycle taking the left pixel and one cycle presenting wren.
    always_comb begin
        state_nxt      = state;
        p_nxt          = p;
        col_nxt        = col;
        center_nxt     = center_px;
        right_nxt      = right_px;
        left_nxt       = left_px;
        wr_phase_nxt   = wr_phase;
        wren_nxt       = wren;
        data_write_nxt = data_write;
        address_nxt    = address;
        done_nxt       = x_pixel_filling_done;

        if (!enable_x_pixel_filling) begin
            state_nxt      = IDLE;
            wr_phase_nxt   = 1'b0;
            wren_nxt       = 1'b0;
            data_write_nxt = 32'd0;
            address_nxt    = 18'd0;
            done_nxt       = 1'b0;
        end else begin
            case (state)
                IDLE: state_nxt = INIT;
                INIT: begin
                    p_nxt       = FIRST_P;
                    col_nxt     = 9'd0;
                    address_nxt = FIRST_P;
                    wren_nxt    = 1'b0;
                    done_nxt    = 1'b0;
                    state_nxt   = NEXT;
                end
                RD_C: begin
                    address_nxt = p_inc;
                    state_nxt   = RD_R;
                end
                RD_R: begin
                    center_nxt  = data_read;
                    address_nxt = p - 18'd1;
                    state_nxt   = RD_L;
                end
                RD_L: begin
                    right_nxt   = data_read;
                    address_nxt = p;
                    state_nxt   = WRITE;
                end
                WRITE: begin
                    if (!wr_phase) begin
                        left_nxt       = data_read;
                        data_write_nxt = (data_read == FILL && right_px == FILL) ? FILL : center_px;
                        wren_nxt       = 1'b1;
                        wr_phase_nxt   = 1'b1;
                    end else begin
                        wren_nxt     = 1'b0;
                        wr_phase_nxt = 1'b0;
                        state_nxt    = NEXT;
                    end
                end
                NEXT: begin
                    wren_nxt = 1'b0;
                    p_nxt    = p_inc;
                    col_nxt  = (col == LAST_COL) ? 9'd0 : col + 9'd1;
                    if (p_inc == END_P) begin
                        address_nxt = 18'd0;
                        done_nxt    = 1'b1;
                        state_nxt   = DONE;
                    end else begin
                        address_nxt = p_inc;
                        // edge columns are skipped so a fill never wraps across rows
                        state_nxt   = (col_nxt == 9'd0 || col_nxt == LAST_COL) ? NEXT : RD_C;
                    end
                end
                DONE: begin
                    wren_nxt    = 1'b0;
                    address_nxt = 18'd0;
                    done_nxt    = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_div_by_two or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            p                    <= 18'd0;
            col                  <= 9'd0;
            center_px            <= 32'd0;
            right_px             <= 32'd0;
            left_px              <= 32'd0;
            wr_phase             <= 1'b0;
            wren                 <= 1'b0;
            data_write           <= 32'd0;
            address              <= 18'd0;
            x_pixel_filling_done <= 1'b0;
        end else if (!pause) begin
            state                <= state_nxt;
            p                    <= p_nxt;
            col                  <= col_nxt;
            center_px            <= center_nxt;
            right_px             <= right_nxt;
            left_px              <= left_nxt;
            wr_phase             <= wr_phase_nxt;
            wren                 <= wren_nxt;
            data_write           <= data_write_nxt;
            address              <= address_nxt;
            x_pixel_filling_done <= done_nxt;
        end
    end

endmodule

// File: doc/x_pixel_filling.md
X_PIXEL_FILLING -- requirements
Module: x_pixel_filling

Interface
REQ-001 SHALL have ports clk_div_by_two (in, 1, sole clock, rising edge) and reset (in, 1, asynchronous, active-high).
REQ-002 SHALL have port pause (in, 1): when high, all state and outputs are frozen.
REQ-003 SHALL have port enable_x_pixel_filling (in, 1): run request from the sequencer.
REQ-004 SHALL have port data_read (in, 32): RAM read data, valid one clock after address is presented.
REQ-005 SHALL have outputs wren (1), data_write (32), address (18): the shared frame RAM port, 320x240 words, one word per pixel.
REQ-006 SHALL have output x_pixel_filling_done (1): frame-complete flag, feeding the downstream y_pixel_filling enable.

Function
REQ-007 SHALL implement states IDLE, INIT, RD_C, RD_R, RD_L, WRITE, NEXT, DONE.
REQ-008 SHALL transition IDLE->INIT on enable high; INIT loads p=2240, col=0, address=2240, wren=0.
REQ-009 SHALL, for interior columns (1..318): RD_C drives address=p; RD_R captures center and drives p+1; RD_L captures right and drives p-1; WRITE captures left.
REQ-010 SHALL compute the result in WRITE: 1 if left==1 and right==1, else center unchanged (full 32-bit compare).
REQ-011 SHALL, in WRITE, drive wren=1, address=p, data_write=result for exactly one cycle.
REQ-012 SHALL, in NEXT, drive wren=0, increment p, and wrap col 319->0 (otherwise col+1).
REQ-013 SHALL treat columns 0 and 319 as one NEXT cycle with no reads and no write, so no fill crosses row boundaries.
REQ-014 SHALL process addresses 2240..74559 (rows 7..232) and enter DONE when p reaches 74560.
REQ-015 SHALL take 6 cycles per interior pixel and 1 cycle per edge pixel.
REQ-016 SHALL, in DONE, hold x_pixel_filling_done=1, wren=0 and address=0 while enable stays high.
REQ-017 SHALL, on enable low in any state, return to IDLE next edge with done=0, address=0, data_write=0, wren=0.
REQ-018 SHALL give pause=1 priority over enable: no state, counter or output change, including a wren=1 held in WRITE.
REQ-019 SHALL use an 18-bit p and a 9-bit col; no arithmetic path may exceed 18 bits.

Reset
REQ-020 SHALL, on reset high, immediately force IDLE, wren=0, data_write=0, address=0, x_pixel_filling_done=0, p=0, col=0, and clear the pixel buffers, independent of clock or pause.
REQ-021 SHALL, after reset deassertion with enable high, start from INIT, with no resume of a partial frame.

Verification
REQ-022 SHALL pass: RAM[5000]=1, [5001]=0, [5002]=1 -> single write, address 5001, data 1.
REQ-023 SHALL pass: RAM[5000]=1, [5001]=7, [5002]=0 -> write address 5001, data 7.
REQ-024 SHALL pass: RAM[2558]=1, [2560]=1, [2559]=0 (col 319) -> no wren with address 2559; RAM[2559] stays 0.
REQ-025 SHALL pass: pause high 10 cycles during WRITE -> wren stays 1 with address/data stable, then the sequence resumes exactly.
REQ-026 SHALL pass: reset pulse mid-frame -> outputs 0 in the same cycle; re-enable restarts at address 2240.
REQ-027 SHALL pass: full frame -> first write 2241, last write 74558, then done=1; done drops one cycle after enable falls.
